// File: rtl/lsu_dcache_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module   : lsu_dcache_arb_pkg
// Brief    : Shared types for the LSU / store-buffer DCache request arbiter.
// Revision : 1.0 - initial release
// =============================================================================
package lsu_dcache_arb_pkg;

    typedef enum logic [1:0] {
        LSU_OP_LOAD  = 2'd0,
        LSU_OP_STORE = 2'd1,
        LSU_OP_CACOP = 2'd2
    } lsu_op_e;

    typedef struct packed {
        lsu_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [5:0]  rob_id;
    } iq_lsu_pkg_t;

    typedef enum logic {
        SRC_IQ = 1'b0,
        SRC_SB = 1'b1
    } lsu_src_e;

    typedef struct packed {
        lsu_src_e src;
        logic     kill;
    } lsu_tag_t;

    // Committed-store tags survive a flush; speculative IQ tags are marked dead.
    function automatic lsu_tag_t tag_flush(input lsu_tag_t t);
        lsu_tag_t r;
        r = t;
        if (t.src == SRC_IQ) begin
            r.kill = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dcache_arb_tag_fifo.sv
`default_nettype none
// =============================================================================
// Module   : lsu_tag_fifo
// Brief    : In-order source tag FIFO for outstanding DCache requests.
// Revision : 1.0 - initial release
// =============================================================================
module lsu_tag_fifo
    import lsu_dcache_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  lsu_tag_t                 i_push_tag,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output lsu_tag_t                 o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    lsu_tag_t         r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Later push assignment overrides the flush update for the written slot.
    always_ff @(posedge clk) begin
        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= tag_flush(r_mem[i]);
            end
        end
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dcache_arb.sv
`default_nettype none
// =============================================================================
// Module   : lsu_dcache_arb
// Brief    : IQ / store-buffer arbiter for the single DCache port with
//            in-order response routing and flush-safe tag tracking.
// Revision : 1.0 - initial release
// =============================================================================
module lsu_dcache_arb
    import lsu_dcache_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int RESP_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        iq_valid_i,
    output logic        iq_ready_o,
    input  iq_lsu_pkg_t iq_req_i,
    input  logic        sb_valid_i,
    output logic        sb_ready_o,
    input  iq_lsu_pkg_t sb_req_i,
    input  logic        sb_almost_full_i,
    output logic        dc_valid_o,
    input  logic        dc_ready_i,
    output iq_lsu_pkg_t dc_req_o,
    output lsu_src_e    dc_src_o,
    input  logic        dc_resp_valid_i,
    output logic        dc_resp_ready_o,
    output logic        iq_resp_valid_o,
    input  logic        iq_resp_ready_i,
    output logic        sb_resp_valid_o,
    input  logic        sb_resp_ready_i
);

    localparam int                c_SW          = $clog2(STARVE_LIMIT + 1);
    localparam int                c_AW          = $clog2(RESP_DEPTH);
    localparam logic [c_SW-1:0]   c_STARVE_MAX  = c_SW'(STARVE_LIMIT);
    localparam logic [c_AW+1:0]   c_DEPTH       = (c_AW + 2)'(RESP_DEPTH);

    logic              r_dc_valid;
    iq_lsu_pkg_t       r_dc_req;
    lsu_src_e          r_dc_src;
    logic [c_SW-1:0]   r_starve_cnt;

    logic              w_load_en;
    logic              w_accept;
    logic [c_AW+1:0]   w_inflight;
    logic              w_credit;
    logic              w_grant_ok;
    logic              w_sel_sb;
    logic              w_sel_iq;
    logic              w_iq_ready;
    logic              w_sb_ready;

    lsu_tag_t          w_push_tag;
    lsu_tag_t          w_head;
    logic              w_empty;
    logic [c_AW:0]     w_tag_count;
    logic              w_pop;

    assign w_load_en = !r_dc_valid || dc_ready_i;
    assign w_accept  = r_dc_valid && dc_ready_i;

    // An accepted output entry only moves into the tag FIFO, so in-flight
    // work after this cycle is tags + output entry, before any new grant.
    assign w_inflight = {1'b0, w_tag_count} + (c_AW + 2)'(r_dc_valid);
    assign w_credit   = (w_inflight < c_DEPTH);
    assign w_grant_ok = w_load_en && w_credit;

    assign w_sel_sb   = sb_valid_i &&
                        (sb_almost_full_i || (r_starve_cnt == c_STARVE_MAX) || !iq_valid_i);
    assign w_sel_iq   = !w_sel_sb && iq_valid_i;
    assign w_iq_ready = w_grant_ok && w_sel_iq && !flush;
    assign w_sb_ready = w_grant_ok && w_sel_sb;

    assign iq_ready_o = w_iq_ready;
    assign sb_ready_o = w_sb_ready;
    assign dc_valid_o = r_dc_valid;
    assign dc_req_o   = r_dc_req;
    assign dc_src_o   = r_dc_src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dc_valid <= 1'b0;
            r_dc_req   <= '0;
            r_dc_src   <= SRC_IQ;
        end else if (w_iq_ready || w_sb_ready) begin
            r_dc_valid <= 1'b1;
            r_dc_req   <= w_sb_ready ? sb_req_i : iq_req_i;
            r_dc_src   <= w_sb_ready ? SRC_SB : SRC_IQ;
        end else if (w_accept || (flush && (r_dc_src == SRC_IQ))) begin
            r_dc_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!sb_valid_i || w_sb_ready) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + c_SW'(1);
        end
    end

    // An IQ request leaving during a flush is already dead on arrival.
    assign w_push_tag.src  = r_dc_src;
    assign w_push_tag.kill = flush && (r_dc_src == SRC_IQ);

    lsu_tag_fifo #(
        .DEPTH      (RESP_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_accept),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .i_flush    (flush),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_count    (w_tag_count)
    );

    always_comb begin
        iq_resp_valid_o = 1'b0;
        sb_resp_valid_o = 1'b0;
        dc_resp_ready_o = 1'b0;
        if (!w_empty) begin
            if (w_head.src == SRC_SB) begin
                sb_resp_valid_o = dc_resp_valid_i;
                dc_resp_ready_o = sb_resp_ready_i;
            end else if (w_head.kill) begin
                dc_resp_ready_o = 1'b1;
            end else begin
                iq_resp_valid_o = dc_resp_valid_i;
                dc_resp_ready_o = iq_resp_ready_i;
            end
        end
    end

    assign w_pop = dc_resp_valid_i && dc_resp_ready_o;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dcache_arb.sv
`default_nettype none
// =============================================================================
// Module   : tb_lsu_dcache_arb
// Brief    : Self-checking directed bench for lsu_dcache_arb.
// Revision : 1.0 - initial release
// =============================================================================
module tb_lsu_dcache_arb;
    import lsu_dcache_arb_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int RESP_DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        iq_valid_i;
    logic        iq_ready_o;
    iq_lsu_pkg_t iq_req_i;
    logic        sb_valid_i;
    logic        sb_ready_o;
    iq_lsu_pkg_t sb_req_i;
    logic        sb_almost_full_i;
    logic        dc_valid_o;
    logic        dc_ready_i;
    iq_lsu_pkg_t dc_req_o;
    lsu_src_e    dc_src_o;
    logic        dc_resp_valid_i;
    logic        dc_resp_ready_o;
    logic        iq_resp_valid_o;
    logic        iq_resp_ready_i;
    logic        sb_resp_valid_o;
    logic        sb_resp_ready_i;

    lsu_dcache_arb #(
        .STARVE_LIMIT     (STARVE_LIMIT),
        .RESP_DEPTH       (RESP_DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .iq_valid_i       (iq_valid_i),
        .iq_ready_o       (iq_ready_o),
        .iq_req_i         (iq_req_i),
        .sb_valid_i       (sb_valid_i),
        .sb_ready_o       (sb_ready_o),
        .sb_req_i         (sb_req_i),
        .sb_almost_full_i (sb_almost_full_i),
        .dc_valid_o       (dc_valid_o),
        .dc_ready_i       (dc_ready_i),
        .dc_req_o         (dc_req_o),
        .dc_src_o         (dc_src_o),
        .dc_resp_valid_i  (dc_resp_valid_i),
        .dc_resp_ready_o  (dc_resp_ready_o),
        .iq_resp_valid_o  (iq_resp_valid_o),
        .iq_resp_ready_i  (iq_resp_ready_i),
        .sb_resp_valid_o  (sb_resp_valid_o),
        .sb_resp_ready_i  (sb_resp_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iq_v;
        logic sb_v;
        logic af;
        logic fl;
        logic exp_iq_rdy;
        logic exp_sb_rdy;
    } vec_t;

    vec_t vecs [9];
    int   n_total    = 0;
    int   n_pass     = 0;
    int   n_mon_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush            = 1'b0;
        iq_valid_i       = 1'b0;
        iq_req_i         = '0;
        sb_valid_i       = 1'b0;
        sb_req_i         = '0;
        sb_almost_full_i = 1'b0;
        dc_ready_i       = 1'b0;
        dc_resp_valid_i  = 1'b0;
        iq_resp_ready_i  = 1'b0;
        sb_resp_ready_i  = 1'b0;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic iq_lsu_pkg_t mk(input lsu_op_e op, input logic [31:0] a);
        iq_lsu_pkg_t p;
        p.op     = op;
        p.addr   = a;
        p.wdata  = ~a;
        p.be     = 4'hf;
        p.rob_id = a[5:0];
        return p;
    endfunction

    // A response with no outstanding tag leaves every routing output low.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dc_resp_valid_i && !iq_resp_valid_o &&
            !sb_resp_valid_o && !dc_resp_ready_o) begin
            n_mon_fail++;
            $display("FAIL resp_on_empty: response with empty tag FIFO at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           iq sb af fl  iqr sbr
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        reset_dut();
        #1;
        chk("rst_dc_valid", dc_valid_o, 1'b0);
        chk("rst_dc_req", dc_req_o, '0);
        chk("rst_dc_src", dc_src_o, SRC_IQ);
        chk("rst_dc_resp_ready", dc_resp_ready_o, 1'b0);
        chk("rst_iq_resp_valid", iq_resp_valid_o, 1'b0);
        chk("rst_sb_resp_valid", sb_resp_valid_o, 1'b0);
        chk("rst_iq_ready", iq_ready_o, 1'b0);
        chk("rst_sb_ready", sb_ready_o, 1'b0);

        // Priority table from idle; inputs drop before each clock edge
        for (int i = 0; i < 9; i++) begin
            iq_valid_i       = vecs[i].iq_v;
            sb_valid_i       = vecs[i].sb_v;
            sb_almost_full_i = vecs[i].af;
            flush            = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_iq_ready", i), iq_ready_o, vecs[i].exp_iq_rdy);
            chk($sformatf("vec%0d_sb_ready", i), sb_ready_o, vecs[i].exp_sb_rdy);
            idle();
            step();
        end

        // IQ-only back-to-back loads
        reset_dut();
        dc_ready_i = 1'b1;
        iq_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iq_req_i = mk(LSU_OP_LOAD, 32'h100 + 32'(4 * k));
            #1;
            chk($sformatf("b2b_iq_ready%0d", k), iq_ready_o, 1'b1);
            step();
            chk($sformatf("b2b_dc_valid%0d", k), dc_valid_o, 1'b1);
            chk($sformatf("b2b_dc_req%0d", k), dc_req_o, mk(LSU_OP_LOAD, 32'h100 + 32'(4 * k)));
            chk($sformatf("b2b_dc_src%0d", k), dc_src_o, SRC_IQ);
        end
        iq_valid_i = 1'b0;
        step();
        chk("b2b_dc_valid_drop", dc_valid_o, 1'b0);
        dc_resp_valid_i = 1'b1;
        iq_resp_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("b2b_iq_resp%0d", k), iq_resp_valid_o, 1'b1);
            chk($sformatf("b2b_sb_resp%0d", k), sb_resp_valid_o, 1'b0);
            step();
        end
        dc_resp_valid_i = 1'b0;
        #1;
        chk("b2b_drained_resp_ready", dc_resp_ready_o, 1'b0);

        // Contention: SB forced through after STARVE_LIMIT losses
        reset_dut();
        iq_valid_i      = 1'b1;
        sb_valid_i      = 1'b1;
        dc_ready_i      = 1'b1;
        iq_resp_ready_i = 1'b1;
        sb_resp_ready_i = 1'b1;
        iq_req_i        = mk(LSU_OP_LOAD, 32'h40);
        sb_req_i        = mk(LSU_OP_STORE, 32'h80);
        for (int c = 0; c < 7; c++) begin
            dc_resp_valid_i = (c >= 2);
            #1;
            chk($sformatf("starve_iq_ready_c%0d", c), iq_ready_o, (c != 4));
            chk($sformatf("starve_sb_ready_c%0d", c), sb_ready_o, (c == 4));
            chk($sformatf("starve_iq_resp_c%0d", c), iq_resp_valid_o, (c >= 2 && c < 6));
            chk($sformatf("starve_sb_resp_c%0d", c), sb_resp_valid_o, (c == 6));
            step();
        end

        // Backpressure holds the output register
        reset_dut();
        dc_ready_i = 1'b1;
        iq_valid_i = 1'b1;
        iq_req_i   = mk(LSU_OP_LOAD, 32'hA0);
        step();
        dc_ready_i = 1'b0;
        iq_req_i   = mk(LSU_OP_CACOP, 32'hB0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_iq_ready_c%0d", c), iq_ready_o, 1'b0);
            chk($sformatf("bp_dc_req_c%0d", c), dc_req_o, mk(LSU_OP_LOAD, 32'hA0));
            chk($sformatf("bp_dc_valid_c%0d", c), dc_valid_o, 1'b1);
            step();
        end
        dc_ready_i = 1'b1;
        #1;
        chk("bp_release_iq_ready", iq_ready_o, 1'b1);
        step();
        chk("bp_release_dc_req", dc_req_o, mk(LSU_OP_CACOP, 32'hB0));

        // Credit exhaustion with no responses returned
        reset_dut();
        dc_ready_i = 1'b1;
        iq_valid_i = 1'b1;
        sb_req_i   = mk(LSU_OP_STORE, 32'h300);
        for (int c = 0; c < 7; c++) begin
            iq_req_i         = mk(LSU_OP_LOAD, 32'h200 + 32'(4 * c));
            sb_valid_i       = (c >= 4);
            sb_almost_full_i = (c >= 4);
            #1;
            chk($sformatf("credit_iq_ready_c%0d", c), iq_ready_o, (c < 4));
            chk($sformatf("credit_sb_ready_c%0d", c), sb_ready_o, 1'b0);
            step();
        end
        dc_resp_valid_i = 1'b1;
        iq_resp_ready_i = 1'b1;
        #1;
        chk("credit_pop_iq_resp", iq_resp_valid_o, 1'b1);
        chk("credit_pop_sb_ready", sb_ready_o, 1'b0);
        step();
        dc_resp_valid_i = 1'b0;
        #1;
        chk("credit_regained_sb_ready", sb_ready_o, 1'b1);
        chk("credit_regained_iq_ready", iq_ready_o, 1'b0);
        step();
        chk("credit_sb_dc_src", dc_src_o, SRC_SB);
        chk("credit_sb_dc_req", dc_req_o, mk(LSU_OP_STORE, 32'h300));

        // Flush: IQ, SB, IQ tags outstanding plus a stalled IQ request
        reset_dut();
        dc_ready_i = 1'b1;
        iq_valid_i = 1'b1;
        iq_req_i   = mk(LSU_OP_LOAD, 32'h10);
        #1;
        chk("fl_grant_i1", iq_ready_o, 1'b1);
        step();
        iq_valid_i       = 1'b0;
        sb_valid_i       = 1'b1;
        sb_almost_full_i = 1'b1;
        sb_req_i         = mk(LSU_OP_STORE, 32'h20);
        #1;
        chk("fl_grant_s1", sb_ready_o, 1'b1);
        step();
        sb_valid_i       = 1'b0;
        sb_almost_full_i = 1'b0;
        iq_valid_i       = 1'b1;
        iq_req_i         = mk(LSU_OP_LOAD, 32'h30);
        #1;
        chk("fl_grant_i2", iq_ready_o, 1'b1);
        step();
        iq_req_i = mk(LSU_OP_LOAD, 32'h34);
        #1;
        chk("fl_grant_i3", iq_ready_o, 1'b1);
        step();
        iq_valid_i = 1'b0;
        dc_ready_i = 1'b0;
        flush      = 1'b1;
        #1;
        chk("fl_held_req", dc_req_o, mk(LSU_OP_LOAD, 32'h34));
        step();
        flush = 1'b0;
        chk("fl_dc_valid_dropped", dc_valid_o, 1'b0);
        dc_resp_valid_i = 1'b1;
        #1;
        chk("fl_r0_iq_resp", iq_resp_valid_o, 1'b0);
        chk("fl_r0_sb_resp", sb_resp_valid_o, 1'b0);
        chk("fl_r0_discard", dc_resp_ready_o, 1'b1);
        step();
        chk("fl_r1_sb_resp", sb_resp_valid_o, 1'b1);
        chk("fl_r1_wait", dc_resp_ready_o, 1'b0);
        sb_resp_ready_i = 1'b1;
        #1;
        chk("fl_r1_ready", dc_resp_ready_o, 1'b1);
        step();
        chk("fl_r2_iq_resp", iq_resp_valid_o, 1'b0);
        chk("fl_r2_discard", dc_resp_ready_o, 1'b1);
        step();
        dc_resp_valid_i = 1'b0;
        #1;
        chk("fl_drained", dc_resp_ready_o, 1'b0);

        // Flush in the same cycle the IQ request is accepted
        reset_dut();
        dc_ready_i = 1'b1;
        iq_valid_i = 1'b1;
        iq_req_i   = mk(LSU_OP_LOAD, 32'h60);
        step();
        iq_valid_i = 1'b0;
        flush      = 1'b1;
        step();
        flush = 1'b0;
        chk("flacc_dc_valid", dc_valid_o, 1'b0);
        dc_resp_valid_i = 1'b1;
        #1;
        chk("flacc_iq_resp", iq_resp_valid_o, 1'b0);
        chk("flacc_discard", dc_resp_ready_o, 1'b1);
        step();
        dc_resp_valid_i = 1'b0;

        // Reset mid-burst
        reset_dut();
        dc_ready_i = 1'b1;
        iq_valid_i = 1'b1;
        iq_req_i   = mk(LSU_OP_LOAD, 32'h400);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rstmid_dc_valid", dc_valid_o, 1'b0);
        chk("rstmid_dc_req", dc_req_o, '0);
        rst_n    = 1'b1;
        iq_req_i = mk(LSU_OP_LOAD, 32'h500);
        #1;
        chk("rstmid_iq_ready", iq_ready_o, 1'b1);
        step();
        chk("rstmid_dc_valid_new", dc_valid_o, 1'b1);
        chk("rstmid_dc_req_new", dc_req_o, mk(LSU_OP_LOAD, 32'h500));
        iq_valid_i = 1'b0;
        step();
        dc_resp_valid_i = 1'b1;
        iq_resp_ready_i = 1'b1;
        #1;
        chk("rstmid_first_resp_iq", iq_resp_valid_o, 1'b1);
        step();
        dc_resp_valid_i = 1'b0;
        #1;
        chk("rstmid_fifo_empty", dc_resp_ready_o, 1'b0);

        idle();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total + n_mon_fail);
        $finish;
    end

endmodule
`default_nettype wire
